axi_mem_slv: RTL
================

Name: axi_mem_slv

Overview:
- Parametrised AXI4 slave memory for simulation and FPGA: generalised successor to the fixed 128-bit/16K-word AXI SRAM slave behind the core's io_mem_chn port.
- Adds configurable data width, depth and base address, FIXED/INCR/WRAP bursts, ID echo, programmable read latency, and DECERR/SLVERR responses.
- Read and write channels run independently over one single-port-per-direction word array.

Parameters:
- DW, 128, data bus width in bits (64/128/256).
- AW, 14, word-address bits; depth = 2**AW words of DW bits.
- ADDR_W, 32, AXI address width.
- ID_W, 1, AXI ID width.
- BASE, 32'h8000_0000, byte address of word 0.
- RD_LAT, 1, cycles from AR accept to first R beat valid (>=1).

Ports:
- clock  in  1  single clock
- reset  in  1  synchronous, active-high
- ar_valid/ar_ready  in/out  1  read address handshake
- ar_id/ar_addr/ar_len/ar_size/ar_burst  in  ID_W/ADDR_W/8/3/2  read request
- r_valid  out  1, r_ready  in  1  read data handshake
- r_id/r_data/r_resp/r_last  out  ID_W/DW/2/1  read beat
- aw_valid/aw_ready  in/out  1  write address handshake
- aw_id/aw_addr/aw_len/aw_size/aw_burst  in  ID_W/ADDR_W/8/3/2  write request
- w_valid/w_ready  in/out  1, w_data/w_strb/w_last  in  DW/DW/8/1  write data
- b_valid  out  1, b_ready  in  1, b_id/b_resp  out  ID_W/2  write response

Behaviour:
- Reset, synchronous: both FSMs go to IDLE; ar_ready, aw_ready, w_ready, r_valid and b_valid are 0 during reset. r_*/b_* payloads reset to 0. Array contents are not cleared.
- Read FSM IDLE->LAT->BURST->IDLE. ar_ready=1 only in IDLE. On AR handshake, latch id/addr/len/size/burst, set beat counter = len, load latency counter = RD_LAT-1.
- LAT counts down to 0, then enters BURST with r_valid=1. RD_LAT=1 gives r_valid the cycle after the AR handshake.
- BURST: r_data holds while r_valid & !r_ready. Each handshake advances the address; the next beat is valid the following cycle, so back-to-back beats run at 1/cycle. r_last=1 when beat counter==0; the handshake on the last beat returns to IDLE.
- Write FSM IDLE->DATA->RESP->IDLE. aw_ready=1 only in IDLE; w_ready=1 only in DATA.
- DATA: each W handshake writes the bytes selected by w_strb at the current word, then advances the address. The beat with w_last=1, or beat counter==0, moves to RESP. A w_last mismatch against len sets the sticky resp to SLVERR.
- RESP: b_valid=1 and b_id=latched id; b_resp holds until b_ready.
- Next address, per beat:
  - FIXED: unchanged.
  - INCR: addr + (1<<size).
  - WRAP: boundary = (len+1)<<size; addr = start_aligned + ((addr + (1<<size) - start_aligned) mod boundary).
  - Word index = (addr - BASE) >> log2(DW/8); arithmetic is ADDR_W wide and carries out are discarded.
- Errors, checked at the A handshake and per beat:
  - Address outside [BASE, BASE + 2**AW*DW/8): resp DECERR (2'b11), r_data=0, writes dropped.
  - size > log2(DW/8), WRAP with len not in {1,3,7,15}, or burst==2'b11: SLVERR (2'b10) for the whole burst, accesses suppressed.
  - Otherwise resp OKAY (2'b00).
- A burst crossing the top of memory returns OKAY for in-range beats and DECERR for the rest. The write response reports the worst resp seen.
- Narrow transfers: r_data returns the full word; lane selection is the master's job. Writes obey w_strb only.
- Read-during-write to the same word in the same cycle returns the old data.
- Simultaneous AR and AW handshakes are accepted in the same cycle.
- Reset asserted mid-burst aborts both FSMs immediately. No further beats or responses are produced; a partial write remains in memory.

Decomposition:
- Package axi_mem_pkg: burst encodings (FIXED/INCR/WRAP), resp codes (OKAY/SLVERR/DECERR), read and write state enums, and a function for log2(DW/8).
- Sub-module axi_burst_addr: combinational next-address/wrap calculator, instantiated once per channel.

Test Plan:
- Reset released, then AR INCR addr=BASE+0x10, len=3, size=4 (DW=128): four beats, words 1..4, r_last on beat 4 only, r_resp=0, first r_valid exactly RD_LAT cycles after the AR handshake.
- AW WRAP addr=BASE+0x30, len=3, size=4, strb=all-ones: writes words 3,0,1,2. A following read of words 0..3 matches, and b_resp=0 with b_id echoed.
- Write strobe 16'h00F0 with data all-ones onto a zeroed word: only bytes 4..7 become FF. Hold b_ready=0 for 5 cycles: b_valid stays asserted and stable.
- AR addr=BASE-0x10: single beat with r_resp=2'b11 and r_data=0. AR WRAP len=2: r_resp=2'b10 on all 3 beats.
- Hold r_ready low for 3 cycles mid-burst: r_data and r_last stay stable. Assert reset mid-burst: r_valid drops next cycle and ar_ready returns to 1 after reset deasserts.
- AR and AW issued in the same cycle to different words: both complete with OKAY, and read data reflects contents prior to the write.

Source files
------------

// File: rtl/axi_mem_slv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_mem_pkg
// Description : Shared encodings for the AXI4 slave memory: burst types,
//               response codes, read/write FSM state codes and small helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package axi_mem_pkg;

    // AXI burst type encodings
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    // AXI response codes; numeric order doubles as severity order
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Read FSM states
    typedef logic [1:0] rd_state_t;
    localparam rd_state_t RS_IDLE  = 2'd0;
    localparam rd_state_t RS_LAT   = 2'd1;
    localparam rd_state_t RS_BURST = 2'd2;

    // Write FSM states
    typedef logic [1:0] wr_state_t;
    localparam wr_state_t WS_IDLE = 2'd0;
    localparam wr_state_t WS_DATA = 2'd1;
    localparam wr_state_t WS_RESP = 2'd2;

    // log2 of the number of bytes in one data word
    function automatic int log2_bytes(input int dw);
        return $clog2(dw / 8);
    endfunction

    // Worse of two responses (DECERR > SLVERR > OKAY)
    function automatic logic [1:0] resp_worst(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi_mem_slv_burst_addr.sv
`default_nettype none
// ============================================================================
// Module      : axi_burst_addr
// Description : Combinational AXI next-beat address calculator for FIXED,
//               INCR and WRAP bursts. All arithmetic is ADDR_W wide and
//               carries out of the top bit are discarded.
// Ports       : addr  - address of the current beat
//               start - address of the first beat (wrap anchor)
//               len/size/burst - AXI burst attributes
//               next  - address of the following beat
// Revision    : 1.0 - initial release
// ============================================================================
module axi_burst_addr
    import axi_mem_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [ADDR_W-1:0] start,
    input  logic [7:0]        len,
    input  logic [2:0]        size,
    input  logic [1:0]        burst,
    output logic [ADDR_W-1:0] next
);

    logic [ADDR_W-1:0] incr;
    logic [ADDR_W-1:0] bound;
    logic [ADDR_W-1:0] mask;
    logic [ADDR_W-1:0] aligned;

    always_comb begin
        incr    = ADDR_W'(1) << size;
        // Wrap boundary is a power of two for every legal WRAP length, so
        // the modulo reduces to a mask.
        bound   = ADDR_W'({1'b0, len} + 9'd1) << size;
        mask    = bound - ADDR_W'(1);
        aligned = start & ~mask;
        case (burst)
            BURST_FIXED: next = addr;
            BURST_INCR:  next = addr + incr;
            BURST_WRAP:  next = aligned + ((addr + incr - aligned) & mask);
            default:     next = addr + incr;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/axi_mem_slv.sv
`default_nettype none
// ============================================================================
// Module      : axi_mem_slv
// Description : Parametrised AXI4 slave memory. Independent read and write
//               FSMs share one word array; FIXED/INCR/WRAP bursts, ID echo,
//               programmable read latency, DECERR/SLVERR responses.
// Ports       : clock, reset (synchronous, active-high)
//               AR/R  - read address and read data channels
//               AW/W/B - write address, write data and write response
// Revision    : 1.0 - initial release
// ============================================================================
module axi_mem_slv
    import axi_mem_pkg::*;
#(
    parameter int                DW     = 128,
    parameter int                AW     = 14,
    parameter int                ADDR_W = 32,
    parameter int                ID_W   = 1,
    parameter logic [ADDR_W-1:0] BASE   = 'h8000_0000,
    parameter int                RD_LAT = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ar_valid,
    output logic              ar_ready,
    input  logic [ID_W-1:0]   ar_id,
    input  logic [ADDR_W-1:0] ar_addr,
    input  logic [7:0]        ar_len,
    input  logic [2:0]        ar_size,
    input  logic [1:0]        ar_burst,
    output logic              r_valid,
    input  logic              r_ready,
    output logic [ID_W-1:0]   r_id,
    output logic [DW-1:0]     r_data,
    output logic [1:0]        r_resp,
    output logic              r_last,
    input  logic              aw_valid,
    output logic              aw_ready,
    input  logic [ID_W-1:0]   aw_id,
    input  logic [ADDR_W-1:0] aw_addr,
    input  logic [7:0]        aw_len,
    input  logic [2:0]        aw_size,
    input  logic [1:0]        aw_burst,
    input  logic              w_valid,
    output logic              w_ready,
    input  logic [DW-1:0]     w_data,
    input  logic [DW/8-1:0]   w_strb,
    input  logic              w_last,
    output logic              b_valid,
    input  logic              b_ready,
    output logic [ID_W-1:0]   b_id,
    output logic [1:0]        b_resp
);

    localparam int LOG2B = log2_bytes(DW);
    localparam int DEPTH = 2 ** AW;

    logic [DW-1:0] mem [DEPTH];

    // Offset from BASE wraps around for addresses below BASE, so a single
    // unsigned compare covers both ends of the window.
    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] off;
        off = a - BASE;
        return (off >> (AW + LOG2B)) == '0;
    endfunction

    function automatic logic [AW-1:0] word_idx(input logic [ADDR_W-1:0] a);
        return AW'((a - BASE) >> LOG2B);
    endfunction

    function automatic logic req_bad(input logic [2:0] size, input logic [7:0] len,
                                     input logic [1:0] burst);
        return (int'(size) > LOG2B) || (burst == BURST_RSVD) ||
               ((burst == BURST_WRAP) && !(len inside {8'd1, 8'd3, 8'd7, 8'd15}));
    endfunction

    function automatic logic [1:0] beat_resp(input logic bad, input logic [ADDR_W-1:0] a);
        if (bad)          return RESP_SLVERR;
        else if (!in_range(a)) return RESP_DECERR;
        else              return RESP_OKAY;
    endfunction

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    rd_state_t         rd_state;
    logic [ADDR_W-1:0] rd_addr;
    logic [ADDR_W-1:0] rd_start;
    logic [ADDR_W-1:0] rd_next;
    logic [7:0]        rd_len;
    logic [2:0]        rd_size;
    logic [1:0]        rd_burst;
    logic [7:0]        rd_cnt;
    logic              rd_bad;
    logic [7:0]        lat_cnt;
    logic              ar_fire;
    logic              r_fire;

    // Beat about to be presented on R: source depends on where it is loaded from
    logic [ADDR_W-1:0] ld_addr;
    logic              ld_bad;
    logic [7:0]        ld_cnt;
    logic [1:0]        ld_resp;
    logic [DW-1:0]     ld_data;

    assign ar_ready = !reset && (rd_state == RS_IDLE);
    assign ar_fire  = ar_valid && ar_ready;
    assign r_fire   = r_valid && r_ready;

    axi_burst_addr #(.ADDR_W(ADDR_W)) u_rd_addr (
        .addr  (rd_addr),
        .start (rd_start),
        .len   (rd_len),
        .size  (rd_size),
        .burst (rd_burst),
        .next  (rd_next)
    );

    always_comb begin
        ld_addr = rd_next;
        ld_bad  = rd_bad;
        ld_cnt  = rd_cnt - 8'd1;
        if (rd_state == RS_IDLE) begin
            ld_addr = ar_addr;
            ld_bad  = req_bad(ar_size, ar_len, ar_burst);
            ld_cnt  = ar_len;
        end else if (rd_state == RS_LAT) begin
            ld_addr = rd_addr;
            ld_cnt  = rd_cnt;
        end
        ld_resp = beat_resp(ld_bad, ld_addr);
        ld_data = (ld_resp == RESP_OKAY) ? mem[word_idx(ld_addr)] : '0;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rd_state <= RS_IDLE;
            rd_addr  <= '0;
            rd_start <= '0;
            rd_len   <= '0;
            rd_size  <= '0;
            rd_burst <= '0;
            rd_cnt   <= '0;
            rd_bad   <= 1'b0;
            lat_cnt  <= '0;
            r_valid  <= 1'b0;
            r_id     <= '0;
            r_data   <= '0;
            r_resp   <= '0;
            r_last   <= 1'b0;
        end else begin
            case (rd_state)
                RS_IDLE: begin
                    if (ar_fire) begin
                        rd_addr  <= ar_addr;
                        rd_start <= ar_addr;
                        rd_len   <= ar_len;
                        rd_size  <= ar_size;
                        rd_burst <= ar_burst;
                        rd_cnt   <= ar_len;
                        rd_bad   <= req_bad(ar_size, ar_len, ar_burst);
                        r_id     <= ar_id;
                        // With unit latency the first beat is loaded straight
                        // from the AR handshake; otherwise LAT waits RD_LAT-1 cycles.
                        if (RD_LAT == 1) begin
                            rd_state <= RS_BURST;
                            r_valid  <= 1'b1;
                            r_data   <= ld_data;
                            r_resp   <= ld_resp;
                            r_last   <= (ld_cnt == 8'd0);
                        end else begin
                            rd_state <= RS_LAT;
                            lat_cnt  <= 8'(RD_LAT - 2);
                        end
                    end
                end
                RS_LAT: begin
                    if (lat_cnt == 8'd0) begin
                        rd_state <= RS_BURST;
                        r_valid  <= 1'b1;
                        r_data   <= ld_data;
                        r_resp   <= ld_resp;
                        r_last   <= (ld_cnt == 8'd0);
                    end else begin
                        lat_cnt <= lat_cnt - 8'd1;
                    end
                end
                RS_BURST: begin
                    if (r_fire) begin
                        if (rd_cnt == 8'd0) begin
                            rd_state <= RS_IDLE;
                            r_valid  <= 1'b0;
                            r_last   <= 1'b0;
                        end else begin
                            rd_addr <= rd_next;
                            rd_cnt  <= ld_cnt;
                            r_data  <= ld_data;
                            r_resp  <= ld_resp;
                            r_last  <= (ld_cnt == 8'd0);
                        end
                    end
                end
                default: rd_state <= RS_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    wr_state_t         wr_state;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] wr_start;
    logic [ADDR_W-1:0] wr_next;
    logic [7:0]        wr_len;
    logic [2:0]        wr_size;
    logic [1:0]        wr_burst;
    logic [7:0]        wr_cnt;
    logic              wr_bad;
    logic [1:0]        wr_resp;
    logic [ID_W-1:0]   wr_id;
    logic              aw_fire;
    logic              w_fire;
    logic [1:0]        wr_beat_resp;
    logic              wr_mismatch;
    logic              wr_done;
    logic [1:0]        wr_resp_new;
    logic              mem_we;

    assign aw_ready     = !reset && (wr_state == WS_IDLE);
    assign w_ready      = !reset && (wr_state == WS_DATA);
    assign aw_fire      = aw_valid && aw_ready;
    assign w_fire       = w_valid && w_ready;
    assign wr_beat_resp = beat_resp(wr_bad, wr_addr);
    // w_last must coincide with the final counted beat
    assign wr_mismatch  = w_last != (wr_cnt == 8'd0);
    assign wr_done      = w_last || (wr_cnt == 8'd0);
    assign wr_resp_new  = resp_worst(resp_worst(wr_resp, wr_beat_resp),
                                     wr_mismatch ? RESP_SLVERR : RESP_OKAY);
    assign mem_we       = w_fire && (wr_beat_resp == RESP_OKAY);

    axi_burst_addr #(.ADDR_W(ADDR_W)) u_wr_addr (
        .addr  (wr_addr),
        .start (wr_start),
        .len   (wr_len),
        .size  (wr_size),
        .burst (wr_burst),
        .next  (wr_next)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_state <= WS_IDLE;
            wr_addr  <= '0;
            wr_start <= '0;
            wr_len   <= '0;
            wr_size  <= '0;
            wr_burst <= '0;
            wr_cnt   <= '0;
            wr_bad   <= 1'b0;
            wr_resp  <= RESP_OKAY;
            wr_id    <= '0;
            b_valid  <= 1'b0;
            b_id     <= '0;
            b_resp   <= '0;
        end else begin
            case (wr_state)
                WS_IDLE: begin
                    if (aw_fire) begin
                        wr_state <= WS_DATA;
                        wr_addr  <= aw_addr;
                        wr_start <= aw_addr;
                        wr_len   <= aw_len;
                        wr_size  <= aw_size;
                        wr_burst <= aw_burst;
                        wr_cnt   <= aw_len;
                        wr_bad   <= req_bad(aw_size, aw_len, aw_burst);
                        wr_resp  <= RESP_OKAY;
                        wr_id    <= aw_id;
                    end
                end
                WS_DATA: begin
                    if (w_fire) begin
                        if (wr_done) begin
                            wr_state <= WS_RESP;
                            b_valid  <= 1'b1;
                            b_id     <= wr_id;
                            b_resp   <= wr_resp_new;
                        end else begin
                            wr_addr <= wr_next;
                            wr_cnt  <= wr_cnt - 8'd1;
                            wr_resp <= wr_resp_new;
                        end
                    end
                end
                WS_RESP: begin
                    if (b_ready) begin
                        wr_state <= WS_IDLE;
                        b_valid  <= 1'b0;
                    end
                end
                default: wr_state <= WS_IDLE;
            endcase
        end
    end

    // Array write; a same-cycle read sees the old word through ld_data.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            for (int i = 0; i < DW / 8; i++) begin
                if (w_strb[i]) begin
                    mem[word_idx(wr_addr)][8*i +: 8] <= w_data[8*i +: 8];
                end
            end
        end
    end

endmodule
`default_nettype wire
